hline_burst_master: RTL and testbench

Fixed-length AXI4 burst master sitting directly downstream of the horizontal-line z-buffer sequencer in `hline_zbuff`. It turns the sequencer's `rd_req`/`wr_req`/`addr`/`byteenable` requests into single AXI4 INCR bursts, as follows:

- **Read path:** read beats go into the z-read FIFO.
- **Write path:** write beats are sourced from the z-out (or pixel) FIFO, with per-word byte enables taken from the byte-enable FIFO.
- **Completion:** `axi_done` pulses on completion, which advances the sequencer.

---
 rtl/hline_burst_master.sv | 201 ++++++++++++++++++++
 tb/tb_hline_burst_master.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hline_burst_master.sv
// hline_burst_master: turns the z-buffer sequencer's read/write requests into
// single fixed-length AXI4 INCR bursts. Read beats are pushed into the z-read
// FIFO, write beats are popped from the write-source and byte-enable FIFOs,
// and axi_done pulses once per finished burst to advance the sequencer.
module hline_burst_master #(
  parameter int BURST_LEN = 256,
  parameter int DATA_W    = 32
) (
  input  logic                  clk,
  input  logic                  nreset,
  // sequencer side
  input  logic                  rd_req,
  input  logic                  wr_req,
  input  logic [31:0]           addr,
  input  logic                  byteenable,
  input  logic [DATA_W-1:0]     wsrc_data,
  input  logic                  wsrc_empty,
  output logic                  wsrc_rd,
  output logic                  be_rd,
  output logic [DATA_W-1:0]     zfifo_wdata,
  output logic                  zfifo_wr,
  input  logic                  zfifo_full,
  output logic                  axi_done,
  output logic                  axi_err,
  // AXI read address channel
  output logic [31:0]           m_araddr,
  output logic [7:0]            m_arlen,
  output logic [2:0]            m_arsize,
  output logic [1:0]            m_arburst,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  // AXI read data channel
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rlast,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  // AXI write address channel
  output logic [31:0]           m_awaddr,
  output logic [7:0]            m_awlen,
  output logic [2:0]            m_awsize,
  output logic [1:0]            m_awburst,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  // AXI write data channel
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wstrb,
  output logic                  m_wlast,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  // AXI write response channel
  input  logic [1:0]            m_bresp,
  input  logic                  m_bvalid,
  output logic                  m_bready
);

  localparam int         STRB_W    = DATA_W / 8;
  localparam logic [8:0] LAST_BEAT = 9'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR_ADDR,
    S_WR_DATA,
    S_WR_RESP,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_addr;
  logic [8:0]  r_beat;
  logic        r_err;

  logic        w_accept;
  logic        w_rdBeat;
  logic        w_wrBeat;
  logic        w_isLast;

  // A read beat only transfers when the z-read FIFO has room, so the FIFO can never overflow.
  assign w_accept = (r_state == S_IDLE) && (rd_req || wr_req);
  assign w_rdBeat = (r_state == S_RD_DATA) && m_rvalid && !zfifo_full;
  assign w_wrBeat = (r_state == S_WR_DATA) && !wsrc_empty && m_wready;
  assign w_isLast = (r_beat == LAST_BEAT);

  assign m_araddr    = r_addr;
  assign m_awaddr    = r_addr;
  assign m_arlen     = 8'(BURST_LEN - 1);
  assign m_awlen     = 8'(BURST_LEN - 1);
  assign m_arsize    = 3'($clog2(STRB_W));
  assign m_awsize    = 3'($clog2(STRB_W));
  assign m_arburst   = 2'b01;
  assign m_awburst   = 2'b01;
  assign m_wdata     = wsrc_data;
  assign m_wstrb     = {STRB_W{byteenable}};
  assign zfifo_wdata = m_rdata;
  assign axi_err     = r_err;

  // State register; reset aborts any burst in flight immediately.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode plus the handshake/pop/push strobes, which depend only on the current state and live inputs.
  always_comb begin
    w_next    = r_state;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    zfifo_wr  = 1'b0;
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_wlast   = 1'b0;
    wsrc_rd   = 1'b0;
    be_rd     = 1'b0;
    m_bready  = 1'b0;
    axi_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rd_req) begin
          w_next = S_RD_ADDR;
        end else if (wr_req) begin
          w_next = S_WR_ADDR;
        end
      end
      S_RD_ADDR: begin
        m_arvalid = 1'b1;
        if (m_arready) begin
          w_next = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        m_rready = !zfifo_full;
        zfifo_wr = w_rdBeat;
        if (w_rdBeat && (w_isLast || m_rlast)) begin
          w_next = S_DONE;
        end
      end
      S_WR_ADDR: begin
        m_awvalid = 1'b1;
        if (m_awready) begin
          w_next = S_WR_DATA;
        end
      end
      S_WR_DATA: begin
        m_wvalid = !wsrc_empty;
        m_wlast  = w_isLast;
        wsrc_rd  = w_wrBeat;
        be_rd    = w_wrBeat;
        if (w_wrBeat && w_isLast) begin
          w_next = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        m_bready = 1'b1;
        if (m_bvalid) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        axi_done = 1'b1;
        w_next   = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Burst bookkeeping: address/counter/error capture on acceptance, beat counting, sticky error on bad responses or rlast misplacement.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_addr <= 32'd0;
      r_beat <= 9'd0;
      r_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr <= addr;
        r_beat <= 9'd0;
        r_err  <= 1'b0;
      end
      if (w_rdBeat) begin
        r_beat <= r_beat + 9'd1;
        if ((m_rresp != 2'b00) || (m_rlast != w_isLast)) begin
          r_err <= 1'b1;
        end
      end
      if (w_wrBeat) begin
        r_beat <= r_beat + 9'd1;
      end
      if ((r_state == S_WR_RESP) && m_bvalid && (m_bresp != 2'b00)) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hline_burst_master.sv
// tb_hline_burst_master: directed bursts against hline_burst_master with a
// queue-based scoreboard. Stimulus tasks push the expected AR/AW addresses,
// read pushes, write beats and done/error outcomes; a negedge monitor pops and
// compares whenever the DUT shows the matching handshake or pulse.
module tb_hline_burst_master;

  localparam int BL      = 256;
  localparam int DW      = 32;
  localparam int MAXWAIT = 1000;

  logic          clk;
  logic          nreset;
  logic          rd_req;
  logic          wr_req;
  logic [31:0]   addr;
  logic          byteenable;
  logic [DW-1:0] wsrc_data;
  logic          wsrc_empty;
  logic          wsrc_rd;
  logic          be_rd;
  logic [DW-1:0] zfifo_wdata;
  logic          zfifo_wr;
  logic          zfifo_full;
  logic          axi_done;
  logic          axi_err;
  logic [31:0]   m_araddr;
  logic [7:0]    m_arlen;
  logic [2:0]    m_arsize;
  logic [1:0]    m_arburst;
  logic          m_arvalid;
  logic          m_arready;
  logic [DW-1:0] m_rdata;
  logic [1:0]    m_rresp;
  logic          m_rlast;
  logic          m_rvalid;
  logic          m_rready;
  logic [31:0]   m_awaddr;
  logic [7:0]    m_awlen;
  logic [2:0]    m_awsize;
  logic [1:0]    m_awburst;
  logic          m_awvalid;
  logic          m_awready;
  logic [DW-1:0] m_wdata;
  logic [3:0]    m_wstrb;
  logic          m_wlast;
  logic          m_wvalid;
  logic          m_wready;
  logic [1:0]    m_bresp;
  logic          m_bvalid;
  logic          m_bready;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } wbeat_t;

  logic [31:0] expRd[$];
  logic [31:0] expAr[$];
  logic [31:0] expAw[$];
  wbeat_t      expWr[$];
  logic        expDone[$];

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  longint lastDoneCyc = 0;
  int     doneCount = 0;
  bit     bpEnable = 0;

  hline_burst_master #(.BURST_LEN(BL), .DATA_W(DW)) dut (
    .clk(clk), .nreset(nreset),
    .rd_req(rd_req), .wr_req(wr_req), .addr(addr), .byteenable(byteenable),
    .wsrc_data(wsrc_data), .wsrc_empty(wsrc_empty), .wsrc_rd(wsrc_rd), .be_rd(be_rd),
    .zfifo_wdata(zfifo_wdata), .zfifo_wr(zfifo_wr), .zfifo_full(zfifo_full),
    .axi_done(axi_done), .axi_err(axi_err),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter advanced on the active edge, read only away from it.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Hang guard.
  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] a);
    rd_req = rd;
    wr_req = wr;
    addr   = a;
  endtask

  // Backpressure source: toggles zfifo_full every 3 cycles while enabled.
  initial begin
    int cnt;
    cnt = 0;
    zfifo_full = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bpEnable) begin
        cnt++;
        if (cnt == 3) begin
          zfifo_full = ~zfifo_full;
          cnt = 0;
        end
      end else begin
        zfifo_full = 1'b0;
        cnt = 0;
      end
    end
  end

  // Scoreboard monitor: compares every DUT handshake/pulse against the queued expectation.
  initial begin
    logic [31:0] eAddr;
    wbeat_t      eBeat;
    logic        eErr;
    forever begin
      @(negedge clk);
      if (nreset) begin
        if (zfifo_full) checkOutput("noPushWhenFull", zfifo_wr, 0);
        if (wsrc_empty) checkOutput("wvalidLowWhenEmpty", m_wvalid, 0);
        if (zfifo_wr) begin
          if (expRd.size() == 0) checkOutput("unexpectedPush", zfifo_wr, 0);
          else begin
            eAddr = expRd.pop_front();
            checkOutput("zfifoData", zfifo_wdata, eAddr);
          end
        end
        if (m_arvalid && m_arready) begin
          if (expAr.size() == 0) checkOutput("unexpectedAr", m_arvalid, 0);
          else begin
            eAddr = expAr.pop_front();
            checkOutput("araddr", m_araddr, eAddr);
            checkOutput("arlenSizeBurst", {m_arlen, m_arsize, m_arburst}, {8'd255, 3'd2, 2'b01});
          end
        end
        if (m_awvalid && m_awready) begin
          if (expAw.size() == 0) checkOutput("unexpectedAw", m_awvalid, 0);
          else begin
            eAddr = expAw.pop_front();
            checkOutput("awaddr", m_awaddr, eAddr);
            checkOutput("awlenSizeBurst", {m_awlen, m_awsize, m_awburst}, {8'd255, 3'd2, 2'b01});
          end
        end
        if (m_wvalid && m_wready) begin
          if (expWr.size() == 0) checkOutput("unexpectedWBeat", m_wvalid, 0);
          else begin
            eBeat = expWr.pop_front();
            checkOutput("wdata", m_wdata, eBeat.data);
            checkOutput("wstrb", m_wstrb, eBeat.strb);
            checkOutput("wlast", m_wlast, eBeat.last);
            checkOutput("popsOnBeat", {wsrc_rd, be_rd}, 2'b11);
          end
        end else if (wsrc_rd || be_rd) begin
          checkOutput("popWithoutBeat", {wsrc_rd, be_rd}, 2'b00);
        end
        if (axi_done) begin
          doneCount++;
          lastDoneCyc = cyc;
          if (expDone.size() == 0) checkOutput("unexpectedDone", axi_done, 0);
          else begin
            eErr = expDone.pop_front();
            checkOutput("doneErr", axi_err, eErr);
          end
        end
      end
    end
  end

  // Bounded wait for an AR handshake (0), AW handshake (1) or done pulse (2); returns at posedge+1 after it.
  task automatic waitFor(input int sel, input string name, output int n);
    bit ok;
    ok = 0;
    n = 0;
    for (int k = 0; k < MAXWAIT; k++) begin
      @(negedge clk);
      case (sel)
        0:       ok = m_arvalid && m_arready;
        1:       ok = m_awvalid && m_awready;
        default: ok = axi_done;
      endcase
      @(posedge clk);
      #1;
      if (ok) break;
      n++;
    end
    if (!ok) checkOutput({name, "Timeout"}, 64'(ok), 1);
  endtask

  // One read burst: pulse request, serve beats 0..lastIdx with data = index, optional error beat.
  task automatic readBurst(input logic [31:0] a, input int errBeat, input int lastIdx,
                           input logic expErr, output longint firstCyc, output longint doneCyc);
    int n;
    bit hs;
    firstCyc = 0;
    expAr.push_back(a);
    expDone.push_back(expErr);
    applyStimulus(1, 0, a);
    @(posedge clk);
    #1;
    applyStimulus(0, 0, 32'hDEAD_BEEF);
    waitFor(0, "ar", n);
    checkOutput("arValidLatency", n, 0);
    checkOutput("errClearedOnAccept", axi_err, 0);
    for (int i = 0; i <= lastIdx; i++) begin
      m_rvalid = 1'b1;
      m_rdata  = 32'(i);
      m_rresp  = (i == errBeat) ? 2'b10 : 2'b00;
      m_rlast  = (i == lastIdx);
      expRd.push_back(32'(i));
      hs = 0;
      for (int k = 0; k < MAXWAIT && !hs; k++) begin
        @(negedge clk);
        hs = m_rready;
        if (hs && i == 0) firstCyc = cyc;
        @(posedge clk);
        #1;
      end
      if (!hs) checkOutput("rBeatTimeout", 64'(hs), 1);
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    m_rresp  = 2'b00;
    waitFor(2, "rdDone", n);
    checkOutput("rdDoneRightAfterLast", n, 0);
    doneCyc = lastDoneCyc;
  endtask

  // Write data + response phase; optional source/ready stalls and an async reset at beat abortAt.
  task automatic writeData(input logic [31:0] base, input bit stall, input logic [1:0] bresp,
                           input int abortAt, output bit aborted);
    int n;
    bit hs;
    aborted = 0;
    waitFor(1, "aw", n);
    for (int i = 0; i < BL; i++) begin
      wsrc_data  = base + 32'(i);
      byteenable = (i % 2 == 0);
      if (i == abortAt) begin
        wsrc_empty = 1'b0;
        #1;
        checkOutput("preResetWvalid", m_wvalid, 1);
        nreset = 1'b0;
        #1;
        checkOutput("resetOutputs",
                    {m_arvalid, m_rready, zfifo_wr, m_awvalid, m_wvalid, m_wlast,
                     wsrc_rd, be_rd, m_bready, axi_done, axi_err}, 0);
        checkOutput("resetAddr", {m_araddr, m_awaddr}, 0);
        expWr.delete();
        expDone.delete();
        wsrc_empty = 1'b1;
        @(posedge clk);
        #1;
        nreset = 1'b1;
        aborted = 1;
        return;
      end
      if (stall && (i % 7 == 3)) begin
        wsrc_empty = 1'b1;
        repeat (2) begin
          @(posedge clk);
          #1;
        end
      end
      wsrc_empty = 1'b0;
      if (stall && (i % 5 == 2)) begin
        m_wready = 1'b0;
        @(posedge clk);
        #1;
        m_wready = 1'b1;
      end
      expWr.push_back('{base + 32'(i), (i % 2 == 0) ? 4'hF : 4'h0, (i == BL - 1)});
      hs = 0;
      for (int k = 0; k < MAXWAIT && !hs; k++) begin
        @(negedge clk);
        hs = m_wvalid && m_wready;
        @(posedge clk);
        #1;
      end
      if (!hs) checkOutput("wBeatTimeout", 64'(hs), 1);
    end
    wsrc_empty = 1'b1;
    m_bvalid = 1'b1;
    m_bresp  = bresp;
    hs = 0;
    for (int k = 0; k < MAXWAIT && !hs; k++) begin
      @(negedge clk);
      hs = m_bready;
      @(posedge clk);
      #1;
    end
    if (!hs) checkOutput("bTimeout", 64'(hs), 1);
    m_bvalid = 1'b0;
    m_bresp  = 2'b00;
  endtask

  initial begin
    longint fc;
    longint dc;
    int     n;
    int     d0;
    bit     ab;

    applyStimulus(0, 0, 32'd0);
    nreset = 1'b0;
    byteenable = 1'b0;
    wsrc_data = '0;
    wsrc_empty = 1'b1;
    m_arready = 1'b1;
    m_rdata = '0;
    m_rresp = 2'b00;
    m_rlast = 1'b0;
    m_rvalid = 1'b0;
    m_awready = 1'b1;
    m_wready = 1'b1;
    m_bresp = 2'b00;
    m_bvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetState",
                {m_arvalid, m_rready, zfifo_wr, m_awvalid, m_wvalid, wsrc_rd, be_rd,
                 m_bready, axi_done, axi_err}, 0);
    checkOutput("resetAddrs", {m_araddr, m_awaddr}, 0);
    nreset = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] zero-wait read burst");
    readBurst(32'h1000_0000, -1, BL - 1, 1'b0, fc, dc);
    checkOutput("rdDoneLatency", dc - fc, 64'd256);
    checkOutput("rdErrClean", axi_err, 0);

    $display("[TB] read burst with z-FIFO backpressure");
    bpEnable = 1;
    readBurst(32'h1000_1000, -1, BL - 1, 1'b0, fc, dc);
    bpEnable = 0;
    checkOutput("rdAllDelivered", expRd.size(), 0);

    $display("[TB] write burst with alternating byte enables");
    expAw.push_back(32'h2000_0400);
    expDone.push_back(1'b0);
    applyStimulus(0, 1, 32'h2000_0400);
    @(posedge clk);
    #1;
    applyStimulus(0, 0, 32'h0BAD_0000);
    writeData(32'hA500_0000, 1'b0, 2'b00, -1, ab);
    waitFor(2, "wrDone", n);
    checkOutput("wrDoneAfterB", n, 0);

    $display("[TB] back-to-back writes with held wr_req");
    d0 = doneCount;
    expAw.push_back(32'h2000_0400);
    expAw.push_back(32'h3000_0400);
    expDone.push_back(1'b0);
    expDone.push_back(1'b0);
    applyStimulus(0, 1, 32'h2000_0400);
    @(posedge clk);
    #1;
    addr = 32'h3000_0400;
    writeData(32'hB600_0000, 1'b0, 2'b00, -1, ab);
    @(negedge clk);
    checkOutput("b2bFirstDone", axi_done, 1);
    @(posedge clk);
    #1;
    checkOutput("b2bIdleNoAw", m_awvalid, 0);
    @(posedge clk);
    #1;
    checkOutput("b2bAwValid", m_awvalid, 1);
    checkOutput("b2bAwAddr", m_awaddr, 32'h3000_0400);
    applyStimulus(0, 0, 32'h0BAD_0001);
    writeData(32'hC700_0000, 1'b0, 2'b00, -1, ab);
    waitFor(2, "b2bDone", n);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("b2bDoneCount", doneCount - d0, 2);

    $display("[TB] read error response and early rlast");
    readBurst(32'h1000_2000, 10, BL - 1, 1'b1, fc, dc);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("errSticky", axi_err, 1);
    readBurst(32'h1000_3000, -1, 100, 1'b1, fc, dc);
    checkOutput("earlyLastBeats", expRd.size(), 0);

    $display("[TB] reset during write data, then clean restart");
    expAw.push_back(32'h2000_0800);
    expDone.push_back(1'b0);
    applyStimulus(0, 1, 32'h2000_0800);
    @(posedge clk);
    #1;
    applyStimulus(0, 0, 32'h0BAD_0002);
    writeData(32'hD800_0000, 1'b0, 2'b00, 50, ab);
    checkOutput("abortTaken", 64'(ab), 1);
    repeat (2) @(posedge clk);
    #1;
    m_awready = 1'b0;
    expAw.push_back(32'h2000_0C00);
    expDone.push_back(1'b1);
    applyStimulus(0, 1, 32'h2000_0C00);
    @(posedge clk);
    #1;
    applyStimulus(0, 0, 32'h0BAD_0003);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("awHeldUntilReady", {m_awvalid, m_awaddr}, {1'b1, 32'h2000_0C00});
    m_awready = 1'b1;
    writeData(32'hE900_0000, 1'b1, 2'b10, -1, ab);
    waitFor(2, "restartDone", n);

    repeat (5) @(posedge clk);
    #1;
    checkOutput("queuesDrained",
                expRd.size() + expWr.size() + expAr.size() + expAw.size() + expDone.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
